// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: encodings, pipeline-register layouts and the op decode helper for the execute stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_stage_pkg;

  // Result classes
  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_ARITH = 3'b100;
  localparam logic [2:0] RES_MUL   = 3'b101;

  // Operation subtypes
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_MUL  = 8'hA9;

  // Iterative multiplier states
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // ID/EX register contents: the decode bundle
  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] reg1;
    logic [31:0] reg2;
  } idex_t;

  // Writeback bundle carried to MEM and on the bypass tap
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } wb_t;

  // True only for alusel/aluop pairs the stage implements; anything else behaves as a NOP.
  function automatic logic op_valid(input logic [2:0] sel, input logic [7:0] op);
    logic v;
    v = 1'b0;
    case (sel)
      RES_LOGIC: v = (op == OP_OR) || (op == OP_AND) || (op == OP_XOR) || (op == OP_NOR);
      RES_SHIFT: v = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
      RES_ARITH: v = (op == OP_ADDU) || (op == OP_SUBU) || (op == OP_SLT);
      RES_MUL:   v = (op == OP_MUL);
      default:   v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: decode-side bundle, stall/flush controls, bypass tap and EX/MEM outputs of the execute stage.
// Latency: n/a (wires only).
// Backpressure: stall_i from the stall controller, stallreq_o back to it.
interface ex_stage_if;
  logic        stall_i;
  logic        flush_i;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic        stallreq_o;
  logic [4:0]  fwd_wd_o;
  logic        fwd_wreg_o;
  logic [31:0] fwd_wdata_o;
  logic [4:0]  mem_wd_o;
  logic        mem_wreg_o;
  logic [31:0] mem_wdata_o;

  // Decode / stall controller / memory side
  modport master (
    output stall_i, flush_i, aluop_i, alusel_i, wd_i, wreg_i, reg1_i, reg2_i,
    input  stallreq_o, fwd_wd_o, fwd_wreg_o, fwd_wdata_o, mem_wd_o, mem_wreg_o, mem_wdata_o
  );

  // Execute stage side
  modport slave (
    input  stall_i, flush_i, aluop_i, alusel_i, wd_i, wreg_i, reg1_i, reg2_i,
    output stallreq_o, fwd_wd_o, fwd_wreg_o, fwd_wdata_o, mem_wd_o, mem_wreg_o, mem_wdata_o
  );
endinterface

// File: rtl/ex_stage_mul_iter.sv
// mul_iter: 32x32 shift-add multiplier returning the low 32 bits of the unsigned product.
// Latency: one IDLE accept cycle, 32 BUSY cycles, result valid during the single DONE cycle.
// Backpressure: none internally; start_i is sampled only in IDLE, clr_i aborts at any time.
module mul_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] res_o
);

  mul_state_e  state_q, state_d;
  logic [31:0] mcand_q, mplier_q, acc_q;
  logic [4:0]  cnt_q;

  // State register; abort returns straight to IDLE
  always_ff @(posedge clk) begin
    if (rst || clr_i) state_q <= MUL_IDLE;
    else              state_q <= state_d;
  end

  // Next state: accept, iterate 32 times, present result for one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: if (start_i) state_d = MUL_BUSY;
      MUL_BUSY: if (cnt_q == 5'd31) state_d = MUL_DONE;
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy_o = (state_q == MUL_BUSY);
    done_o = (state_q == MUL_DONE);
  end

  // Datapath: load operands on accept, one partial product per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        MUL_BUSY: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign res_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: yangMIPS execute stage owning ID/EX, EX/MEM, the result mux and the bypass tap.
// Latency: single-cycle ops on fwd_* one cycle and on mem_* two cycles after presentation; MUL +34.
// Backpressure: stall_i holds ID/EX and bubbles EX/MEM; stallreq_o is raised while a MUL is pending.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);

  idex_t       idex_d, idex_q;
  wb_t         fwd, exmem_d, exmem_q;
  logic [31:0] res;
  logic [31:0] mul_res;
  logic        valid, is_mul, mul_busy, mul_done;

  // ID/EX next state: flush wins over stall, stall holds the current op
  always_comb begin
    idex_d = idex_q;
    if (bus.flush_i) begin
      idex_d = '0;
    end else if (!bus.stall_i) begin
      idex_d.aluop  = bus.aluop_i;
      idex_d.alusel = bus.alusel_i;
      idex_d.wd     = bus.wd_i;
      idex_d.wreg   = bus.wreg_i;
      idex_d.reg1   = bus.reg1_i;
      idex_d.reg2   = bus.reg2_i;
    end
  end

  // ID/EX register; an all-zero entry is the bubble (RES_NOP, wreg 0)
  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign valid  = op_valid(idex_q.alusel, idex_q.aluop);
  assign is_mul = (idex_q.alusel == RES_MUL) && (idex_q.aluop == OP_MUL);

  mul_iter u_mul (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.flush_i),
    .start_i (is_mul),
    .a_i     (idex_q.reg1),
    .b_i     (idex_q.reg2),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .res_o   (mul_res)
  );

  // Result mux; the product is exposed only once the multiplier is in DONE
  always_comb begin
    res = '0;
    case (idex_q.alusel)
      RES_LOGIC: begin
        case (idex_q.aluop)
          OP_OR:   res = idex_q.reg1 | idex_q.reg2;
          OP_AND:  res = idex_q.reg1 & idex_q.reg2;
          OP_XOR:  res = idex_q.reg1 ^ idex_q.reg2;
          OP_NOR:  res = ~(idex_q.reg1 | idex_q.reg2);
          default: res = '0;
        endcase
      end
      RES_SHIFT: begin
        case (idex_q.aluop)
          OP_SLL:  res = idex_q.reg2 << idex_q.reg1[4:0];
          OP_SRL:  res = idex_q.reg2 >> idex_q.reg1[4:0];
          OP_SRA:  res = $unsigned($signed(idex_q.reg2) >>> idex_q.reg1[4:0]);
          default: res = '0;
        endcase
      end
      RES_ARITH: begin
        case (idex_q.aluop)
          OP_ADDU: res = idex_q.reg1 + idex_q.reg2;
          OP_SUBU: res = idex_q.reg1 - idex_q.reg2;
          OP_SLT:  res = {31'd0, ($signed(idex_q.reg1) < $signed(idex_q.reg2))};
          default: res = '0;
        endcase
      end
      RES_MUL: res = mul_done ? mul_res : '0;
      default: res = '0;
    endcase
  end

  // Bypass bundle: unknown ops are fully zeroed, a pending MUL never claims a write
  always_comb begin
    fwd = '0;
    if (valid) begin
      fwd.wd    = idex_q.wd;
      fwd.wreg  = idex_q.wreg & (~is_mul | mul_done);
      fwd.wdata = res;
    end
  end

  assign exmem_d = bus.stall_i ? '0 : fwd;

  // EX/MEM register: bubble under stall, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) exmem_q <= '0;
    else     exmem_q <= exmem_d;
  end

  assign bus.stallreq_o  = mul_busy | (is_mul & ~mul_busy & ~mul_done);
  assign bus.fwd_wd_o    = fwd.wd;
  assign bus.fwd_wreg_o  = fwd.wreg;
  assign bus.fwd_wdata_o = fwd.wdata;
  assign bus.mem_wd_o    = exmem_q.wd;
  assign bus.mem_wreg_o  = exmem_q.wreg;
  assign bus.mem_wdata_o = exmem_q.wdata;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and randomized checks of ex_stage against a behavioural model.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: stall_i either driven directly or tied to stallreq_o.
module tb_ex_stage;

  localparam logic [2:0] S_NOP = 3'b000, S_LOG = 3'b001, S_SHF = 3'b010, S_ARI = 3'b100, S_MUL = 3'b101;
  localparam logic [7:0] O_OR = 8'h25, O_AND = 8'h24, O_XOR = 8'h26, O_NOR = 8'h27;
  localparam logic [7:0] O_SLL = 8'h7C, O_SRL = 8'h02, O_SRA = 8'h03;
  localparam logic [7:0] O_ADDU = 8'h21, O_SUBU = 8'h23, O_SLT = 8'h2A, O_MUL = 8'hA9;

  logic clk = 1'b0;
  logic rst;
  logic tie;
  logic stall_ext;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_stage_if bus();
  assign bus.stall_i = tie ? bus.stallreq_o : stall_ext;

  ex_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [4:0] wd,
                       input logic wreg, input logic [31:0] r1, input logic [31:0] r2);
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.wd_i     = wd;
    bus.wreg_i   = wreg;
    bus.reg1_i   = r1;
    bus.reg2_i   = r2;
  endtask

  task automatic drive_nop();
    drive(8'h00, S_NOP, 5'd0, 1'b0, 32'd0, 32'd0);
  endtask

  function automatic logic [37:0] mem_obs();
    return {bus.mem_wd_o, bus.mem_wreg_o, bus.mem_wdata_o};
  endfunction

  function automatic logic [37:0] fwd_obs();
    return {bus.fwd_wd_o, bus.fwd_wreg_o, bus.fwd_wdata_o};
  endfunction

  // Architectural meaning of each instruction; anything unrecognised writes nothing at all.
  function automatic logic [37:0] ref_op(input logic [7:0] op, input logic [2:0] sel, input logic [4:0] wd,
                                         input logic wreg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    longint unsigned prod;
    bit ok;
    ok = 1'b1;
    d  = 32'd0;
    if      (sel == S_LOG && op == O_OR)   d = a | b;
    else if (sel == S_LOG && op == O_AND)  d = a & b;
    else if (sel == S_LOG && op == O_XOR)  d = a ^ b;
    else if (sel == S_LOG && op == O_NOR)  d = ~(a | b);
    else if (sel == S_SHF && op == O_SLL)  d = b << a[4:0];
    else if (sel == S_SHF && op == O_SRL)  d = b >> a[4:0];
    else if (sel == S_SHF && op == O_SRA)  d = $unsigned($signed(b) >>> a[4:0]);
    else if (sel == S_ARI && op == O_ADDU) d = a + b;
    else if (sel == S_ARI && op == O_SUBU) d = a - b;
    else if (sel == S_ARI && op == O_SLT)  d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    else if (sel == S_MUL && op == O_MUL) begin
      prod = 64'(a) * 64'(b);
      d = prod[31:0];
    end else ok = 1'b0;
    return ok ? {wd, wreg, d} : 38'd0;
  endfunction

  // Present one op for a cycle, then verify the bypass tap and the EX/MEM result.
  task automatic single(input string tag, input logic [7:0] op, input logic [2:0] sel, input logic [4:0] wd,
                        input logic wreg, input logic [31:0] a, input logic [31:0] b, input logic [37:0] exp);
    drive(op, sel, wd, wreg, a, b);
    tick();
    drive_nop();
    check({tag, "_fwd"}, 64'(fwd_obs()), 64'(exp));
    tick();
    check({tag, "_mem"}, 64'(mem_obs()), 64'(exp));
  endtask

  // Entered one cycle after a MUL was captured; counts stall cycles and checks the writeback.
  task automatic mul_wait(input string tag, input logic [31:0] exp, input logic [4:0] wd,
                          input bit chain, input logic [31:0] na, input logic [31:0] nb);
    int n;
    drive_nop();
    n = 0;
    while (bus.stallreq_o === 1'b1 && n < 100) begin
      if (n > 0) check({tag, "_bubble"}, 64'(mem_obs()), 64'd0);
      n++;
      tick();
    end
    check({tag, "_stall_len"}, 64'(n), 64'd33);
    check({tag, "_fwd"}, 64'(fwd_obs()), 64'({wd, 1'b1, exp}));
    if (chain) drive(O_MUL, S_MUL, wd + 5'd1, 1'b1, na, nb);
    tick();
    check({tag, "_mem"}, 64'(mem_obs()), 64'({wd, 1'b1, exp}));
  endtask

  localparam int NRAND = 200;
  logic [2:0]  tsel[10];
  logic [7:0]  top[10];
  logic [37:0] exp_q[NRAND];

  initial begin
    tsel = '{S_LOG, S_LOG, S_LOG, S_LOG, S_SHF, S_SHF, S_SHF, S_ARI, S_ARI, S_ARI};
    top  = '{O_OR, O_AND, O_XOR, O_NOR, O_SLL, O_SRL, O_SRA, O_ADDU, O_SUBU, O_SLT};
    tie = 1'b0;
    stall_ext = 1'b0;
    bus.flush_i = 1'b0;
    drive_nop();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_mem", 64'(mem_obs()), 64'd0);
    check("rst_fwd", 64'(fwd_obs()), 64'd0);
    check("rst_stallreq", 64'(bus.stallreq_o), 64'd0);

    // Directed single-cycle operations
    single("or",   O_OR,   S_LOG, 5'd5, 1'b1, 32'h0000_F0F0, 32'h0000_0F0F, {5'd5, 1'b1, 32'h0000_FFFF});
    single("sra",  O_SRA,  S_SHF, 5'd6, 1'b1, 32'd4,         32'h8000_0000, {5'd6, 1'b1, 32'hF800_0000});
    single("slt",  O_SLT,  S_ARI, 5'd7, 1'b1, 32'hFFFF_FFFF, 32'd1,         {5'd7, 1'b1, 32'd1});
    single("subu", O_SUBU, S_ARI, 5'd8, 1'b1, 32'd0,         32'd1,         {5'd8, 1'b1, 32'hFFFF_FFFF});
    single("nop_sel",  O_OR,  S_NOP, 5'd9, 1'b1, 32'd5, 32'd6, 38'd0);
    single("bad_op",   8'hFF, S_LOG, 5'd9, 1'b1, 32'd5, 32'd6, 38'd0);
    single("bad_mulop", O_OR, S_MUL, 5'd9, 1'b1, 32'd5, 32'd6, 38'd0);

    // External stall holds a single-cycle op, which then leaves exactly once
    drive(O_ADDU, S_ARI, 5'd3, 1'b1, 32'd10, 32'd20);
    tick();
    drive_nop();
    stall_ext = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("hold_fwd", 64'(fwd_obs()), 64'({5'd3, 1'b1, 32'd30}));
      tick();
      check("hold_bubble", 64'(mem_obs()), 64'd0);
    end
    stall_ext = 1'b0;
    tick();
    check("hold_emit", 64'(mem_obs()), 64'({5'd3, 1'b1, 32'd30}));
    tick();
    check("hold_once", 64'(mem_obs()), 64'd0);

    // Multiplies with the stall controller closed around the stage
    tie = 1'b1;
    drive(O_MUL, S_MUL, 5'd7, 1'b1, 32'h0001_0003, 32'h0000_0005);
    tick();
    mul_wait("mul_a", 32'h0005_000F, 5'd7, 1'b0, 32'd0, 32'd0);
    drive(O_MUL, S_MUL, 5'd8, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    mul_wait("mul_b", 32'h0000_0001, 5'd8, 1'b1, 32'd3, 32'd7);
    mul_wait("mul_c", 32'd21, 5'd9, 1'b0, 32'd0, 32'd0);

    // Flush in the middle of a multiply (BUSY with cnt=10)
    drive(O_MUL, S_MUL, 5'd10, 1'b1, 32'd123, 32'd456);
    tick();
    drive_nop();
    repeat (11) tick();
    check("flush_pre_stall", 64'(bus.stallreq_o), 64'd1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("flush_stallreq", 64'(bus.stallreq_o), 64'd0);
    check("flush_fwd", 64'(fwd_obs()), 64'd0);
    tick();
    check("flush_no_wb", 64'(mem_obs()), 64'd0);
    single("flush_addu", O_ADDU, S_ARI, 5'd11, 1'b1, 32'd2, 32'd3, {5'd11, 1'b1, 32'd5});

    // Reset in the middle of a multiply
    drive(O_MUL, S_MUL, 5'd12, 1'b1, 32'd77, 32'd99);
    tick();
    drive_nop();
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmul_stallreq", 64'(bus.stallreq_o), 64'd0);
    check("rstmul_fwd", 64'(fwd_obs()), 64'd0);
    check("rstmul_mem", 64'(mem_obs()), 64'd0);
    tick();
    check("rstmul_idle", 64'(bus.stallreq_o), 64'd0);
    check("rstmul_mem2", 64'(mem_obs()), 64'd0);

    // Reset clears EX/MEM instead of letting the held op through
    tie = 1'b0;
    drive(O_ADDU, S_ARI, 5'd13, 1'b1, 32'd1, 32'd1);
    tick();
    drive_nop();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_exmem", 64'(mem_obs()), 64'd0);

    // Randomized back-to-back single-cycle stream against the model
    for (int i = 0; i < NRAND + 2; i++) begin
      if (i >= 1) check("rand_fwd", 64'(fwd_obs()), 64'(exp_q[i-1]));
      if (i >= 2) check("rand_mem", 64'(mem_obs()), 64'(exp_q[i-2]));
      if (i < NRAND) begin
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] a, b;
        int          pick;
        pick = $urandom_range(0, 11);
        if (pick < 10) begin
          sel = tsel[pick];
          op  = top[pick];
        end else begin
          sel = 3'($urandom);
          op  = 8'($urandom);
          if (sel == S_MUL && op == O_MUL) op = 8'h00;
        end
        wd   = 5'($urandom);
        wreg = 1'($urandom);
        a    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        b    = $urandom;
        drive(op, sel, wd, wreg, a, b);
        exp_q[i] = ref_op(op, sel, wd, wreg, a, b);
      end else begin
        drive_nop();
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
